dmem_responder: RTL and testbench

//   Data-memory responder serving the load/store requests issued by the core's MEM stage.

---
 rtl/riscv_mem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Purpose  : Shared types, constants and helpers for the data-memory
//            responder and its storage array.
// Contents : dmem_state_t  - responder FSM state encoding
//            DMEM_DATA_W   - default data width
//            BE_W          - byte-enable width for the default data width
//            addr_aligned  - word-alignment check on the two address LSBs
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DATA_W = 32;
  localparam int BE_W        = DMEM_DATA_W / 8;

  // A word access is legal only when the byte offset within the word is 0.
  function automatic logic addr_aligned(input logic [1:0] i_lsb);
    return (i_lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Single-port synchronous RAM with per-byte write enables and a
//            registered read port. Contents are not reset.
// Ports    : clk      in   clock, rising edge
//            i_en     in   access enable (read or write this edge)
//            i_we     in   1 = write the enabled byte lanes, 0 = read
//            i_be     in   byte-lane write enables
//            i_idx    in   word index
//            i_wdata  in   write data
//            o_rdata  out  read data, updated on the edge of a read access
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_be[b]) begin
            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        o_rdata <= r_mem[i_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the MEM stage. Accepts one load/store
//            per valid/ready handshake, inserts WAIT_CYCLES wait states,
//            commits byte-enabled stores, and returns a single-cycle
//            response. busy stalls the pipeline while an access is in flight.
// Ports    : clk        in   clock, rising edge
//            reset      in   synchronous, active-high
//            req_valid  in   request present
//            req_ready  out  responder can accept a request
//            req_write  in   1 = store, 0 = load
//            req_addr   in   byte address
//            req_wdata  in   store data
//            req_be     in   store byte enables (ignored for loads)
//            rsp_valid  out  one-cycle response pulse per accepted request
//            rsp_rdata  out  load data; 0 for stores, errors, and outside RESP
//            rsp_err    out  misaligned or out-of-range access
//            busy       out  access in flight
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int NBE   = DATA_W / 8;

  localparam logic [CNT_W-1:0]  C_CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W-3:0] C_DEPTH    = (ADDR_W-2)'(DEPTH_WORDS);

  // Error = misaligned, or full word index (all upper bits) beyond the array.
  function automatic logic f_access_err(input logic [ADDR_W-1:0] i_a);
    return !addr_aligned(i_a[1:0]) || (i_a[ADDR_W-1:2] >= C_DEPTH);
  endfunction

  dmem_state_t          r_state;
  dmem_state_t          w_next;
  logic [CNT_W-1:0]     r_cnt;

  logic                 r_write;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [NBE-1:0]       r_be;

  logic                 w_accept;
  logic                 w_acc_write;
  logic [ADDR_W-1:0]    w_acc_addr;
  logic [DATA_W-1:0]    w_acc_wdata;
  logic [NBE-1:0]       w_acc_be;
  logic                 w_acc_err;
  logic                 w_enter_resp;
  logic                 w_ram_en;
  logic                 w_ram_we;
  logic [DATA_W-1:0]    w_ram_rdata;
  logic                 w_rsp_err;

  assign w_accept = req_valid && (r_state == IDLE);

  // With zero wait states the array is accessed on the accept edge itself,
  // before the capture registers hold the request, so the live request is
  // used while still in IDLE.
  assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_be    = (r_state == IDLE) ? req_be    : r_be;
  assign w_acc_err   = f_access_err(w_acc_addr);

  // Reset on the commit edge drops the request: no write, no response.
  assign w_enter_resp = !reset && (w_next == RESP) && (r_state != RESP);
  assign w_ram_en     = w_enter_resp && !w_acc_err;
  assign w_ram_we     = w_ram_en && w_acc_write;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= C_CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (w_acc_be),
    .i_idx   (w_acc_addr[IDX_W+1:2]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_rsp_err = (r_state == RESP) && f_access_err(r_addr);

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = w_rsp_err;
  assign rsp_rdata = ((r_state == RESP) && !r_write && !w_rsp_err) ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Two instances run side
//            by side: one with two wait states, one with none. A behavioural
//            model per instance tracks memory contents, when the responder is
//            free, and when each response is due; it is compared against the
//            DUT outputs every cycle. Directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WAIT_CYCLES = 2
  logic            a_reset, a_valid, a_write, a_ready, a_rv, a_err, a_busy;
  logic [31:0]     a_addr, a_wdata, a_rdata;
  logic [BE_W-1:0] a_be;
  // Instance B: WAIT_CYCLES = 0
  logic            b_reset, b_valid, b_write, b_ready, b_rv, b_err, b_busy;
  logic [31:0]     b_addr, b_wdata, b_rdata;
  logic [BE_W-1:0] b_be;

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err), .busy(a_busy));

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timeout, no DUT event within bound (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model (index 0 = A, 1 = B) ----------------
  logic [31:0] mem_m [2][256];
  bit          pend [2];
  bit          has_rsp [2];
  bit          chk_en [2];
  int          cyc_m [2];
  int          nfree [2];
  int          commit_c [2];
  int          rsp_c [2];
  logic        p_w [2];
  logic [31:0] p_a [2];
  logic [31:0] p_d [2];
  logic [3:0]  p_be [2];
  logic [31:0] e_rd [2];
  logic        e_er [2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Called once per cycle at the falling edge: compares this cycle's outputs,
  // then advances the model by what the upcoming rising edge will do.
  task automatic mstep(input int k, input logic rst, input logic v, input logic w,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be,
                       input logic rdy, input logic bsy, input logic rv,
                       input logic [31:0] rd, input logic er);
    int    c;
    bit    x_rdy, x_rv;
    logic  bad;
    int    idx;
    string tag;
    c     = cyc_m[k];
    tag   = (k == 0) ? "a" : "b";
    x_rdy = (c >= nfree[k]);
    x_rv  = has_rsp[k] && (c == rsp_c[k]);
    if (chk_en[k]) begin
      chk({tag, " req_ready"}, 32'(rdy), 32'(x_rdy));
      chk({tag, " busy"},      32'(bsy), 32'(!x_rdy));
      chk({tag, " rsp_valid"}, 32'(rv),  32'(x_rv));
      chk({tag, " rsp_rdata"}, rd,       x_rv ? e_rd[k] : 32'h0);
      chk({tag, " rsp_err"},   32'(er),  32'(x_rv && e_er[k]));
    end
    if (rst) begin
      pend[k]    = 1'b0;
      has_rsp[k] = 1'b0;
      nfree[k]   = c + 1;
      chk_en[k]  = 1'b1;
    end else begin
      if (x_rv) has_rsp[k] = 1'b0;
      if (v && x_rdy) begin
        pend[k]     = 1'b1;
        p_w[k]      = w;
        p_a[k]      = ad;
        p_d[k]      = wd;
        p_be[k]     = be;
        commit_c[k] = c + wait_of(k);
        rsp_c[k]    = c + wait_of(k) + 1;
        nfree[k]    = c + wait_of(k) + 2;
      end
      if (pend[k] && (c == commit_c[k])) begin
        bad     = (p_a[k][1:0] != 2'b00) || ((p_a[k] >> 2) >= 32'd256);
        e_er[k] = bad;
        e_rd[k] = 32'h0;
        if (!bad) begin
          idx = int'(p_a[k][9:2]);
          if (p_w[k]) begin
            for (int b = 0; b < 4; b++)
              if (p_be[k][b]) mem_m[k][idx][8*b +: 8] = p_d[k][8*b +: 8];
          end else begin
            e_rd[k] = mem_m[k][idx];
          end
        end
        pend[k]    = 1'b0;
        has_rsp[k] = 1'b1;
      end
    end
    cyc_m[k]++;
  endtask

  always @(negedge clk) mstep(0, a_reset, a_valid, a_write, a_addr, a_wdata, a_be,
                              a_ready, a_busy, a_rv, a_rdata, a_err);
  always @(negedge clk) mstep(1, b_reset, b_valid, b_write, b_addr, b_wdata, b_be,
                              b_ready, b_busy, b_rv, b_rdata, b_err);

  // ---------------- driver ----------------
  // Issues one request (entered just after a rising edge), waits for accept
  // and response, and returns just after the rising edge ending RESP.
  // lat counts cycles from the accept edge to the response cycle.
  task automatic req(input int k, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    int n;
    bit ok;
    rd = 32'h0; er = 1'b0; lat = 0;
    if (k == 0) begin a_valid = 1'b1; a_write = w; a_addr = ad; a_wdata = wd; a_be = be; end
    else        begin b_valid = 1'b1; b_write = w; b_addr = ad; b_wdata = wd; b_be = be; end
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = (k == 0) ? (a_ready === 1'b1) : (b_ready === 1'b1);
      n++;
    end
    if (!ok) begin
      fail_timeout("accept");
      if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (k == 0 && a_rv === 1'b1) begin ok = 1'b1; rd = a_rdata; er = a_err; end
      if (k == 1 && b_rv === 1'b1) begin ok = 1'b1; rd = b_rdata; er = b_err; end
    end
    lat = n;
    if (!ok) fail_timeout("response");
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int kind;
    kind = $urandom_range(0, 9);
    if (kind == 0) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
    if (kind == 1) return ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, acc, bz, rvn;

    a_reset = 1'b1; a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_reset = 1'b1; b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    repeat (3) @(posedge clk);
    #1;
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset a_ready", 32'(a_ready), 32'd1);
    chk("reset a_busy",  32'(a_busy),  32'd0);
    chk("reset a_rv",    32'(a_rv),    32'd0);
    chk("reset a_rdata", a_rdata,      32'h0);
    @(posedge clk); #1;

    // Give every word a known value in both instances
    for (int i = 0; i < 256; i++) begin
      req(0, 1'b1, 32'(i) << 2, $urandom, 4'hF, rd, er, lat);
      req(1, 1'b1, 32'(i) << 2, $urandom, 4'hF, rd, er, lat);
    end

    // Full-word store then load
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("s1 store err", 32'(er), 32'd0);
    chk("s1 store rdata", rd, 32'h0);
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("s1 load rdata", rd, 32'hDEADBEEF);
    chk("s1 load err", 32'(er), 32'd0);
    chk("s1 latency", 32'(lat), 32'd3);

    // Single-byte store merges into the existing word
    req(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, rd, er, lat);
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("s2 load rdata", rd, 32'hDEADBEAA);

    // Misaligned load; out-of-range store must not alias onto word 0
    req(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    chk("s3 misaligned err", 32'(er), 32'd1);
    chk("s3 misaligned rdata", rd, 32'h0);
    req(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, rd, er, lat);
    req(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("s3 range err", 32'(er), 32'd1);
    req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("s3 word0 unchanged", rd, 32'h55AA55AA);

    // Valid held for 10 cycles with a new address every cycle
    acc = 0; bz = 0; rvn = 0;
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1; a_write = 1'b0; a_addr = 32'($urandom_range(0, 255)) << 2;
      @(negedge clk);
      if (a_ready === 1'b1) acc++;
      if (a_busy === 1'b1) bz++;
      if (a_rv === 1'b1) rvn++;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_rv === 1'b1) rvn++;
      @(posedge clk); #1;
    end
    chk("s4 accepts", 32'(acc), 32'd3);
    chk("s4 busy cycles", 32'(bz), 32'd7);
    chk("s4 responses", 32'(rvn), 32'd3);

    // Reset while a store waits: dropped, old data survives
    req(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, er, lat);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678; a_be = 4'hF;
    @(negedge clk);
    chk("s5 accept", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0; a_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0;
    @(negedge clk);
    chk("s5 ready after reset", 32'(a_ready), 32'd1);
    chk("s5 busy after reset", 32'(a_busy), 32'd0);
    rvn = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_rv === 1'b1) rvn++;
      @(negedge clk);
    end
    chk("s5 no response", 32'(rvn), 32'd0);
    @(posedge clk); #1;
    req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("s5 prior value", rd, 32'h0BADF00D);

    // Randomised traffic on A
    for (int i = 0; i < 150; i++) begin
      req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)), rd, er, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Zero wait states
    req(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, lat);
    req(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("s6 load rdata", rd, 32'hCAFEF00D);
    chk("s6 latency", 32'(lat), 32'd1);
    acc = 0; bz = 0; rvn = 0;
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1; b_write = 1'b0; b_addr = 32'($urandom_range(0, 255)) << 2;
      @(negedge clk);
      if (b_ready === 1'b1) acc++;
      if (b_busy === 1'b1) bz++;
      if (b_rv === 1'b1) rvn++;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    chk("s6 accepts", 32'(acc), 32'd4);
    chk("s6 busy cycles", 32'(bz), 32'd4);
    chk("s6 responses", 32'(rvn), 32'd4);
    repeat (2) begin @(posedge clk); #1; end

    // Randomised traffic on B
    for (int i = 0; i < 100; i++) begin
      req(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)), rd, er, lat);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
